// File: rtl/bus_pkg.sv
// Shared types, default address map and decode helpers for the data-bus memory/MMIO slave.
package bus_pkg;

   localparam logic [31:0]  DEF_RAM_BASE  = 32'h0000_1000;
   localparam int unsigned  DEF_RAM_WORDS = 1024;
   localparam logic [31:0]  DEF_TX_ADDR   = 32'h0000_3000;
   localparam logic [31:0]  DEF_RX_ADDR   = 32'h0000_3004;

   typedef enum logic [2:0] {
      SZ_B = 3'd0,
      SZ_H = 3'd1,
      SZ_W = 3'd2
   } size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TXW  = 2'd1,
      RXW  = 2'd2,
      RESP = 2'd3
   } state_t;

   // Byte-lane write enables for an aligned access; reserved sizes enable nothing.
   function automatic logic [3:0] lane_en(input logic [2:0] sz, input logic [1:0] off);
      logic [3:0] en;
      en = 4'b0000;
      case (sz)
         SZ_B:    en = 4'b0001 << off;
         SZ_H:    en = 4'b0011 << off;
         SZ_W:    en = 4'b1111;
         default: en = 4'b0000;
      endcase
      return en;
   endfunction

   function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] off);
      logic m;
      m = 1'b0;
      case (sz)
         SZ_H:    m = off[0];
         SZ_W:    m = (off != 2'd0);
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/bus_ram_bank.sv
// Four independent 8-bit RAM lanes with per-lane write enable and a registered, enabled read.
module bus_ram_bank #(
   parameter int unsigned WORDS = 1024,
   parameter int unsigned AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic          re,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   q
);

   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] mem [WORDS];
      logic [7:0] rd;

      // No reset on the array or read register so the lane maps onto block RAM.
      always_ff @(posedge clk) begin
         if (we[i]) mem[idx] <= wdata[8*i +: 8];
         if (re)    rd       <= mem[idx];
      end

      assign q[8*i +: 8] = rd;
   end

endmodule

// File: rtl/bus_mem_ctrl.sv
// Data-bus slave: decodes each request to RAM, the stdout TTY or the stdin TTY and returns ready/rdata.
module bus_mem_ctrl
   import bus_pkg::*;
#(
   parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
   parameter int unsigned RAM_WORDS = DEF_RAM_WORDS,
   parameter logic [31:0] TX_ADDR   = DEF_TX_ADDR,
   parameter logic [31:0] RX_ADDR   = DEF_RX_ADDR
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic [31:0] addr,
   input  logic [2:0]  size,
   input  logic        valid,
   input  logic        write,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        stdout_valid,
   output logic [7:0]  stdout_data,
   input  logic        stdout_ready,
   output logic        stdin_valid,
   input  logic [7:0]  stdin_data,
   input  logic        stdin_ready
);

   localparam int unsigned AW        = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

   state_t        state, state_d;
   logic          ready_d, err_d, stdout_valid_d, stdin_valid_d;
   logic [7:0]    stdout_data_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          rsel, rsel_d;
   logic [3:0]    ram_we;
   logic          ram_re;
   logic [31:0]   ram_q;
   logic [31:0]   ram_off;
   logic [AW-1:0] ram_idx;
   logic          ram_hit, tx_hit, rx_hit, bad;

   // Address decode, all on 32-bit arithmetic.
   assign ram_off = addr - RAM_BASE;
   assign ram_hit = (addr >= RAM_BASE) && (ram_off < RAM_BYTES);
   assign tx_hit  = (addr == TX_ADDR);
   assign rx_hit  = (addr == RX_ADDR);
   assign bad     = !(ram_hit || tx_hit || rx_hit) || (size > 3'd2) || misaligned(size, addr[1:0]);
   assign ram_idx = AW'(ram_off >> 2);

   bus_ram_bank #(.WORDS(RAM_WORDS), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .idx   (ram_idx),
      .wdata (wdata),
      .q     (ram_q)
   );

   // RAM reads are returned straight from the bank register; other sources from rdata_q.
   assign rdata = rsel ? ram_q : rdata_q;

   always_comb begin
      state_d        = state;
      ready_d        = 1'b0;
      err_d          = err;
      stdout_valid_d = stdout_valid;
      stdout_data_d  = stdout_data;
      stdin_valid_d  = stdin_valid;
      rdata_d        = rdata_q;
      rsel_d         = rsel;
      ram_we         = 4'b0000;
      ram_re         = 1'b0;
      case (state)
         IDLE: begin
            if (valid) begin
               if (bad) begin
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
                  rsel_d  = 1'b0;
                  ready_d = 1'b1;
                  state_d = RESP;
               end else if (ram_hit) begin
                  if (write) begin
                     ram_we = lane_en(size, addr[1:0]);
                  end else begin
                     ram_re = 1'b1;
                     rsel_d = 1'b1;
                  end
                  ready_d = 1'b1;
                  state_d = RESP;
               end else if (tx_hit) begin
                  if (write) begin
                     stdout_valid_d = 1'b1;
                     stdout_data_d  = wdata[7:0];
                     state_d        = TXW;
                  end else begin
                     rdata_d = 32'd0;
                     rsel_d  = 1'b0;
                     ready_d = 1'b1;
                     state_d = RESP;
                  end
               end else begin
                  if (write) begin
                     ready_d = 1'b1;
                     state_d = RESP;
                  end else begin
                     stdin_valid_d = 1'b1;
                     state_d       = RXW;
                  end
               end
            end
         end
         TXW: begin
            if (stdout_ready) begin
               stdout_valid_d = 1'b0;
               ready_d        = 1'b1;
               state_d        = RESP;
            end
         end
         RXW: begin
            if (stdin_ready) begin
               stdin_valid_d = 1'b0;
               rdata_d       = {24'd0, stdin_data};
               rsel_d        = 1'b0;
               ready_d       = 1'b1;
               state_d       = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state        <= IDLE;
         ready        <= 1'b0;
         err          <= 1'b0;
         stdout_valid <= 1'b0;
         stdout_data  <= 8'd0;
         stdin_valid  <= 1'b0;
         rdata_q      <= 32'd0;
         rsel         <= 1'b0;
      end else begin
         state        <= state_d;
         ready        <= ready_d;
         err          <= err_d;
         stdout_valid <= stdout_valid_d;
         stdout_data  <= stdout_data_d;
         stdin_valid  <= stdin_valid_d;
         rdata_q      <= rdata_d;
         rsel         <= rsel_d;
      end
   end

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Directed bench for bus_mem_ctrl: RAM vector tables, TTY handshake sequences, errors and reset.
module tb_bus_mem_ctrl;
   import bus_pkg::*;

   logic        clk = 1'b0;
   logic        rstb;
   logic [31:0] addr;
   logic [2:0]  size;
   logic        valid;
   logic        write;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        err;
   logic        stdout_valid;
   logic [7:0]  stdout_data;
   logic        stdout_ready;
   logic        stdin_valid;
   logic [7:0]  stdin_data;
   logic        stdin_ready;

   int n_tests = 0;
   int n_fail  = 0;

   bus_mem_ctrl dut (
      .clk          (clk),
      .rstb         (rstb),
      .addr         (addr),
      .size         (size),
      .valid        (valid),
      .write        (write),
      .wdata        (wdata),
      .rdata        (rdata),
      .ready        (ready),
      .err          (err),
      .stdout_valid (stdout_valid),
      .stdout_data  (stdout_data),
      .stdout_ready (stdout_ready),
      .stdin_valid  (stdin_valid),
      .stdin_data   (stdin_data),
      .stdin_ready  (stdin_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [31:0] wd;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   function automatic vec_t mk(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                               input logic [31:0] wd, input logic chk_rd,
                               input logic [31:0] exp_rd, input logic exp_err);
      vec_t v;
      v.wr = wr; v.sz = sz; v.a = a; v.wd = wd;
      v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_err = exp_err;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One bus access; returns sampled rdata/err at the ready cycle and cycles from decode to ready.
   task automatic access(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e,
                         output int lat);
      @(negedge clk);
      valid = 1'b1; write = wr; size = sz; addr = a; wdata = wd;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (ready) break;
      end
      rd = rdata;
      e  = err;
      valid = 1'b0;
      @(negedge clk);
      check("ready single pulse", 32'(ready), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] rd;
      logic        e;
      int          lat;
      access(v.wr, v.sz, v.a, v.wd, rd, e, lat);
      check($sformatf("vec%0d latency", idx), 32'(lat), 32'd1);
      if (v.chk_rd) check($sformatf("vec%0d rdata", idx), rd, v.exp_rd);
      check($sformatf("vec%0d err", idx), 32'(e), 32'(v.exp_err));
   endtask

   // TTY access; peer handshake raised at negedge index raise_at (negative: already high).
   task automatic tty_seq(input logic is_tx, input int raise_at, input logic [7:0] rx_byte,
                          output int nv, output int nr, output int first_r,
                          output logic [31:0] rd, output logic [7:0] data_seen);
      nv = 0; nr = 0; first_r = -1; rd = 32'hxxxx_xxxx; data_seen = 8'h00;
      if (raise_at < 0) begin
         stdout_ready = is_tx;
         stdin_ready  = !is_tx;
         stdin_data   = rx_byte;
      end
      @(negedge clk);
      valid = 1'b1; write = is_tx;
      size  = is_tx ? 3'(SZ_B) : 3'(SZ_W);
      addr  = is_tx ? 32'h3000 : 32'h3004;
      wdata = 32'h0000_0041;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge clk);
         if (is_tx ? stdout_valid : stdin_valid) nv++;
         if (is_tx && stdout_valid) data_seen = stdout_data;
         if (ready) begin
            nr++;
            if (first_r < 0) first_r = cyc;
            rd = rdata;
            valid = 1'b0; stdout_ready = 1'b0; stdin_ready = 1'b0;
         end
         if (cyc == raise_at) begin
            if (is_tx) stdout_ready = 1'b1;
            else begin
               stdin_ready = 1'b1;
               stdin_data  = rx_byte;
            end
         end
      end
   endtask

   vec_t        tab_a[12];
   vec_t        tab_b[9];
   int          nv, nr, first_r, lat;
   logic [31:0] rd;
   logic [7:0]  ds;
   logic        e;

   initial begin
      rstb = 1'b0; valid = 1'b0; write = 1'b0; size = 3'd0; addr = 32'd0; wdata = 32'd0;
      stdout_ready = 1'b0; stdin_ready = 1'b0; stdin_data = 8'd0;

      tab_a[0]  = mk(1'b1, SZ_W, 32'h1008, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
      tab_a[1]  = mk(1'b0, SZ_W, 32'h1008, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
      tab_a[2]  = mk(1'b1, SZ_B, 32'h100A, 32'h00AA0000, 1'b0, 32'h0,        1'b0);
      tab_a[3]  = mk(1'b0, SZ_W, 32'h1008, 32'h0,        1'b1, 32'hDEAABEEF, 1'b0);
      tab_a[4]  = mk(1'b1, SZ_H, 32'h1008, 32'h00001234, 1'b0, 32'h0,        1'b0);
      tab_a[5]  = mk(1'b0, SZ_W, 32'h1008, 32'h0,        1'b1, 32'hDEAA1234, 1'b0);
      tab_a[6]  = mk(1'b1, SZ_W, 32'h100C, 32'h12345678, 1'b0, 32'h0,        1'b0);
      tab_a[7]  = mk(1'b0, SZ_B, 32'h100F, 32'h0,        1'b1, 32'h12345678, 1'b0);
      tab_a[8]  = mk(1'b1, SZ_W, 32'h1FFC, 32'hA5A55A5A, 1'b0, 32'h0,        1'b0);
      tab_a[9]  = mk(1'b0, SZ_W, 32'h1FFC, 32'h0,        1'b1, 32'hA5A55A5A, 1'b0);
      tab_a[10] = mk(1'b1, SZ_W, 32'h3004, 32'hFFFFFFFF, 1'b1, 32'hA5A55A5A, 1'b0);
      tab_a[11] = mk(1'b0, SZ_W, 32'h3000, 32'h0,        1'b1, 32'h00000000, 1'b0);

      tab_b[0]  = mk(1'b0, SZ_W, 32'h1008, 32'h0,        1'b1, 32'hDEAA1234, 1'b0);
      tab_b[1]  = mk(1'b0, SZ_W, 32'h1002, 32'h0,        1'b1, 32'h00000000, 1'b1);
      tab_b[2]  = mk(1'b1, SZ_W, 32'h5000, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b1);
      tab_b[3]  = mk(1'b0, SZ_W, 32'h1008, 32'h0,        1'b1, 32'hDEAA1234, 1'b1);
      tab_b[4]  = mk(1'b1, SZ_H, 32'h1009, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1);
      tab_b[5]  = mk(1'b1, 3'd3, 32'h1008, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1);
      tab_b[6]  = mk(1'b1, SZ_W, 32'h2000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1);
      tab_b[7]  = mk(1'b1, SZ_W, 32'h0FFC, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1);
      tab_b[8]  = mk(1'b0, SZ_W, 32'h1008, 32'h0,        1'b1, 32'hDEAA1234, 1'b1);

      #1;
      check("reset ready",        32'(ready),        32'd0);
      check("reset err",          32'(err),          32'd0);
      check("reset stdout_valid", 32'(stdout_valid), 32'd0);
      check("reset stdin_valid",  32'(stdin_valid),  32'd0);
      check("reset rdata",        rdata,             32'd0);
      check("reset stdout_data",  32'(stdout_data),  32'd0);
      @(negedge clk); @(negedge clk);
      rstb = 1'b1;

      for (int i = 0; i < 12; i++) run_vec(tab_a[i], i);

      // stdout accept delayed five cycles
      tty_seq(1'b1, 5, 8'h00, nv, nr, first_r, rd, ds);
      check("tx valid cycles", 32'(nv), 32'd6);
      check("tx ready count",  32'(nr), 32'd1);
      check("tx ready cycle",  32'(first_r), 32'd6);
      check("tx data",         32'(ds), 32'h41);

      // stdout_ready already high on entry
      tty_seq(1'b1, -1, 8'h00, nv, nr, first_r, rd, ds);
      check("tx pre valid cycles", 32'(nv), 32'd1);
      check("tx pre ready cycle",  32'(first_r), 32'd1);

      // stdin data after three cycles
      tty_seq(1'b0, 2, 8'h5A, nv, nr, first_r, rd, ds);
      check("rx valid cycles", 32'(nv), 32'd3);
      check("rx ready count",  32'(nr), 32'd1);
      check("rx ready cycle",  32'(first_r), 32'd3);
      check("rx rdata",        rd, 32'h0000005A);

      // stdin_ready high on the entering edge must not be taken
      tty_seq(1'b0, -1, 8'hC3, nv, nr, first_r, rd, ds);
      check("rx pre ready cycle", 32'(first_r), 32'd1);
      check("rx pre rdata",       rd, 32'h000000C3);
      check("rx pre valid drop",  32'(stdin_valid), 32'd0);

      for (int i = 0; i < 9; i++) run_vec(tab_b[i], 100 + i);

      // reset while waiting on the transmitter
      @(negedge clk);
      valid = 1'b1; write = 1'b1; size = 3'(SZ_B); addr = 32'h3000; wdata = 32'h77;
      @(negedge clk); @(negedge clk);
      check("txw stdout_valid", 32'(stdout_valid), 32'd1);
      #2 rstb = 1'b0;
      #1;
      check("rst stdout_valid", 32'(stdout_valid), 32'd0);
      check("rst ready",        32'(ready),        32'd0);
      check("rst err cleared",  32'(err),          32'd0);
      valid = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      access(1'b0, 3'(SZ_W), 32'h1008, 32'h0, rd, e, lat);
      check("post-reset latency", 32'(lat), 32'd1);
      check("post-reset rdata",   rd, 32'hDEAA1234);
      check("post-reset err",     32'(e), 32'd0);
      check("post-reset no tx",   32'(stdout_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_mem_ctrl.md
# bus_mem_ctrl

Synthesizable memory/MMIO slave for the generated core's `valid`/`ready` data bus, replacing the behavioural RAM and address decode used in simulation benches. Decodes each request to a byte-lane RAM, the stdout TTY transmitter or the stdin TTY receiver. Runs the handshake to each target and returns read data and `ready` to the core.

## Interface
- `RAM_BASE`, default `'h1000`: byte address of RAM word 0.
- `RAM_WORDS`, default 1024: RAM depth in 32-bit words (power of two).
- `TX_ADDR`, default `'h3000`: stdout data register.
- `RX_ADDR`, default `'h3004`: stdin data register.

- `clk` in 1: clock.
- `rstb` in 1: reset, asynchronous, active-low.
- `addr` in 32: byte address, stable while `valid` is high.
- `size` in 3: 0 = byte, 1 = half, 2 = word, others reserved.
- `valid` in 1: request.
- `write` in 1: 1 = write, 0 = read.
- `wdata` in 32: lane-positioned write data; the byte for `addr[1:0]=n` is in `wdata[8n+7:8n]`.
- `rdata` out 32: read data.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: sticky access error.
- `stdout_valid` out 1: TX request to `tty_tx`.
- `stdout_data` out 8: TX byte.
- `stdout_ready` in 1: TX accept.
- `stdin_valid` out 1: RX request to `tty_rx`.
- `stdin_data` in 8: RX byte.
- `stdin_ready` in 1: RX data available.

## Operation
- States:
  - IDLE
  - TXW: waiting on TTY transmit.
  - RXW: waiting on TTY receive.
  - RESP: `ready` is 1.
- Decode happens in IDLE on the edge where `valid=1`.
- **RAM hit** (`RAM_BASE <= addr < RAM_BASE+4*RAM_WORDS`):
  - Write: lane enables come from `size` and `addr[1:0]`. Byte: 1 lane. Half: lanes n, n+1. Word: all 4 lanes. Committed on the decode edge.
  - Read: the full aligned word is returned regardless of `size`; the core extracts the bytes it needs.
  - Next state is RESP.
- **TX_ADDR write**: drive `stdout_data=wdata[7:0]` and `stdout_valid=1`; go to TXW. Leave TXW for RESP on the edge where `stdout_valid && stdout_ready`.
- **TX_ADDR read**: `rdata=0`; go to RESP.
- **RX_ADDR read**: `stdin_valid=1`; go to RXW. On the edge with `stdin_ready=1`, capture `rdata={24'b0,stdin_data}` and go to RESP.
- **RX_ADDR write**: ignored; go to RESP.
- **Errors**: any of the following sets `err` (sticky until reset):
  - unmapped address;
  - `size` ≥ 3;
  - misaligned access (half with `addr[0]=1`, word with `addr[1:0]≠0`).

  No write is performed, `rdata=0`, and the access still completes through RESP.
- **RESP**: `ready=1` for exactly one cycle, then back to IDLE. `valid` is ignored during RESP; the requester drops `valid` or presents a new request after seeing `ready`.
- `rdata` holds its last value until the next read completes.

## Timing
- Reset values: `ready`, `err`, `stdout_valid`, `stdin_valid` = 0; `rdata`, `stdout_data` = 0; state IDLE. RAM contents are not cleared.
- RAM access: `valid` sampled at edge k → `ready` high during cycle k..k+1 → IDLE at k+1. Latency 1 cycle; throughput 1 access per 2 cycles with `valid` held high.
- TTY: latency is 1 + cycles until the peer handshake. `stdout_valid`/`stdin_valid` are registered, rise at edge k, and fall on the accepting edge. No timeout.
- Simultaneous events:
  - `stdout_ready` already high when TXW is entered: accept at edge k+1, `ready` during k+1..k+2.
  - `stdin_ready` high on the entering edge is ignored; the first accepting edge is k+1.
- Reset mid-operation drops the TTY request immediately with no `ready` pulse. A RAM write already committed stays committed.
- Address arithmetic is done on 32 bits. The RAM index is `(addr-RAM_BASE)>>2`, truncated to `$clog2(RAM_WORDS)` bits after the range check.

## Structure
- Package `bus_pkg`:
  - `size_t` enum (`SZ_B`, `SZ_H`, `SZ_W`);
  - `state_t` enum (IDLE, TXW, RXW, RESP);
  - default address constants.
- Sub-module `bus_ram_bank`: four 8-bit-wide banks of `RAM_WORDS` each, one write-enable per lane, registered read. Written so that block-RAM inference works.
- Lane-enable and alignment checks are combinational functions in `bus_pkg`.

## Test plan
- Word write `'hDEADBEEF` to `'h1008`, then word read `'h1008` → `rdata='hDEADBEEF`, `ready` 1 cycle after each `valid`.
- Byte write `wdata='h00AA0000` to `'h100A`, then read `'h1008` → `'hDEAABEEF`. Half write `'h00001234` to `'h1008`, then read → `'hDEAA1234`.
- Write `'h41` to `'h3000` with `stdout_ready` held low 5 cycles → `stdout_valid` high 6 cycles, `stdout_data='h41`, single `ready` after accept.
- Read `'h3004`, bench raises `stdin_ready` with `stdin_data='h5A` after 3 cycles → `rdata='h0000005A`, one `ready`.
- Word read `'h1002` and write to `'h5000` → `err=1`, RAM unchanged, `rdata=0`, `ready` still pulses; `err` stays 1 until `rstb` low.
- Assert `rstb` low while in TXW → `stdout_valid` and `ready` drop to 0 immediately; after release, a fresh RAM read completes normally.
